// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and default widths for the skid-buffered
//                pipeline stage. Holds the stage occupancy enum and the
//                default payload / statistics counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Occupancy of the two-entry stage (main = head, skid = overflow).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_CNT_W  = 16;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_entry_reg
//  Description : One pipeline entry (valid, payload, halt) with write enable
//                and synchronous clear. Reset and clear both load the empty
//                entry: valid=0, payload=FLUSH_VAL, halt=0. Clear wins over
//                a write at the same edge.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_clr             - synchronous clear (flush)
//                i_we              - load i_valid/i_data/i_halt
//                o_valid/o_data/o_halt - registered entry contents
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W    = PIPE_DATA_W,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_halt,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_halt
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_halt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_valid <= 1'b0;
            r_data  <= FLUSH_VAL;
            r_halt  <= 1'b0;
        end else if (i_we) begin
            r_valid <= i_valid;
            r_data  <= i_data;
            r_halt  <= i_halt;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_halt  = r_halt;

endmodule : pipe_entry_reg
`default_nettype wire

// File: rtl/pipeline_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stage_skid
//  Description : Two-entry valid/ready pipeline stage with skid buffer.
//                in_ready comes straight from the skid register, so there is
//                no combinational path from out_ready to in_ready. Outputs are
//                taken from the main (head) entry registers only. flush
//                empties the stage and has priority over push/pop; rst
//                overrides everything.
//  Ports       : clk, rst, flush
//                in_valid/in_ready/in_data/in_halt     - upstream side
//                out_valid/out_ready/out_data/out_halt - downstream side
//                stall_cnt, flush_cnt - saturating statistics counters,
//                present only when PIPE_STAGE_STATS_EN is defined
//  Config      : `define PIPE_STAGE_STATS_EN to build the counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W    = PIPE_DATA_W,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
    parameter int unsigned        CNT_W     = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              w_main_valid, w_main_halt;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid, w_skid_halt;
    logic [DATA_W-1:0] w_skid_data;

    logic              w_push, w_pop;
    pipe_state_e       w_state;

    logic              w_main_we, w_main_d_valid, w_main_d_halt;
    logic [DATA_W-1:0] w_main_d_data;
    logic              w_skid_we, w_skid_d_valid, w_skid_d_halt;
    logic [DATA_W-1:0] w_skid_d_data;

    assign in_ready = ~w_skid_valid;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = w_main_valid & out_ready;

    // The skid entry is only ever filled while main is valid, so the two
    // valid bits fully encode the occupancy.
    always_comb begin
        w_state = ST_EMPTY;
        if (w_main_valid) begin
            w_state = w_skid_valid ? ST_FULL : ST_ONE;
        end
    end

    // Halt is only ever written together with valid=1, and emptying an entry
    // clears its halt bit, so the stored halt is already qualified by valid.
    always_comb begin
        w_main_we      = 1'b0;
        w_main_d_valid = 1'b1;
        w_main_d_data  = in_data;
        w_main_d_halt  = in_halt;
        w_skid_we      = 1'b0;
        w_skid_d_valid = 1'b1;
        w_skid_d_data  = in_data;
        w_skid_d_halt  = in_halt;
        case (w_state)
            ST_EMPTY: begin
                w_main_we = w_push;
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_main_we = 1'b1;
                end else if (w_pop) begin
                    w_main_we      = 1'b1;
                    w_main_d_valid = 1'b0;
                    w_main_d_data  = w_main_data;
                    w_main_d_halt  = 1'b0;
                end else if (w_push) begin
                    w_skid_we = 1'b1;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    w_main_we      = 1'b1;
                    w_main_d_valid = 1'b1;
                    w_main_d_data  = w_skid_data;
                    w_main_d_halt  = w_skid_halt;
                    w_skid_we      = 1'b1;
                    w_skid_d_valid = 1'b0;
                    w_skid_d_data  = w_skid_data;
                    w_skid_d_halt  = 1'b0;
                end
            end
            default: begin
                w_main_we = 1'b0;
                w_skid_we = 1'b0;
            end
        endcase
    end

    pipe_entry_reg #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_we    (w_main_we),
        .i_valid (w_main_d_valid),
        .i_data  (w_main_d_data),
        .i_halt  (w_main_d_halt),
        .o_valid (w_main_valid),
        .o_data  (w_main_data),
        .o_halt  (w_main_halt)
    );

    pipe_entry_reg #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_we    (w_skid_we),
        .i_valid (w_skid_d_valid),
        .i_data  (w_skid_d_data),
        .i_halt  (w_skid_d_halt),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_halt  (w_skid_halt)
    );

    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    assign out_halt  = w_main_halt;

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] c_cnt_one = 1;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_main_valid && !out_ready && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (flush && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule : pipeline_stage_skid
`default_nettype wire

// File: tb/tb_pipeline_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stage_skid
//  Description : Self-checking bench for pipeline_stage_skid. A queue-based
//                model (at most two beats in flight) predicts the outputs;
//                directed scenarios pin the model with literal values, then
//                a randomized run with occasional flush and reset follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_skid;

    localparam int unsigned       DW      = 32;
    localparam int unsigned       CW      = 4;
    localparam logic [DW-1:0]     FV      = '0;
    localparam int                CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_halt, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid, out_halt;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_stage_skid #(
        .DATA_W    (DW),
        .FLUSH_VAL (FV),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_halt   (in_halt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_halt  (out_halt)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          halt;
        logic [DW-1:0] data;
    } beat_t;

    beat_t mq[$];
    bit    cleared = 1'b1;
    bit    chk_en  = 1'b0;
    int    m_stall = 0;
    int    m_flush = 0;

    always @(posedge clk) begin : model
        int sz;
        bit do_pop, do_push;
        sz = mq.size();
        if (rst) begin
            mq.delete();
            cleared = 1'b1;
            m_stall = 0;
            m_flush = 0;
            chk_en  = 1'b1;
        end else begin
            if (sz > 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
            if (flush && m_flush < CNT_MAX) m_flush++;
            if (flush) begin
                mq.delete();
                cleared = 1'b1;
            end else begin
                do_pop  = (sz > 0) && out_ready;
                do_push = in_valid && (sz < 2);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back('{halt: in_halt, data: in_data});
                    cleared = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("in_ready", in_ready, mq.size() < 2);
            chk("out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("out_data", out_data, mq[0].data);
                chk("out_halt", out_halt, mq[0].halt);
            end else begin
                chk("out_halt_idle", out_halt, 1'b0);
                if (cleared) chk("out_data_flushval", out_data, FV);
            end
`ifdef PIPE_STAGE_STATS_EN
            chk("stall_cnt", stall_cnt, m_stall);
            chk("flush_cnt", flush_cnt, m_flush);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic h);
        in_valid = v;
        in_data  = d;
        in_halt  = h;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, FV);
        chk("rst_out_halt", out_halt, 1'b0);
        rst = 1'b0;

        // Streaming: one-cycle latency, never fills.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1000 + i, 1'b0);
            @(negedge clk);
            chk("stream_data", out_data, 32'h1000 + i);
            chk("stream_ready", in_ready, 1'b1);
        end
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("stream_drained", out_valid, 1'b0);

        // Backpressure.
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'hB, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0);
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_head_a", out_data, 32'hA);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_b", out_data, 32'hB);
        chk("bp_valid_b", out_valid, 1'b1);
        @(negedge clk);
        chk("bp_empty", out_valid, 1'b0);

        // Flush priority while FULL.
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h22, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'hC, 1'b0);
        out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_data", out_data, FV);
        chk("flush_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_no_c", out_valid, 1'b0);
        end

        // Halt flag qualified by valid.
        out_ready = 1'b0;
        drive(1'b1, 32'h5, 1'b1);
        @(negedge clk);
        drive(1'b0, '0, 1'b0);
        chk("halt_set", out_halt, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("halt_after_pop", out_halt, 1'b0);
        chk("halt_after_pop_valid", out_valid, 1'b0);

        // Reset while FULL.
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'h88, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0);
        chk("full_before_rst", in_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", in_ready, 1'b1);
        chk("midrst_data", out_data, FV);
        chk("midrst_halt", out_halt, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
        chk("midrst_stall_cnt", stall_cnt, 0);
        chk("midrst_flush_cnt", flush_cnt, 0);

        // Saturating stall counter, then three flush pulses.
        drive(1'b1, 32'h99, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0);
        repeat (20) @(negedge clk);
        chk("stall_sat", stall_cnt, 15);
        for (int i = 0; i < 3; i++) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            @(negedge clk);
        end
        chk("flush_cnt3", flush_cnt, 3);
`endif

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom % 150) == 0;
            flush     = ($urandom % 40) == 0;
            out_ready = ($urandom % 3) != 0;
            drive(($urandom % 4) != 0, $urandom, $urandom % 2);
            @(negedge clk);
        end
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, 1'b0);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_stage_skid
`default_nettype wire
